// File: rtl/add_share_arbiter_pkg.sv
// Shared definitions for the add_share_arbiter block: FSM encoding,
// default datapath width and the signed-overflow helper.
package add_share_arbiter_pkg;

  localparam int W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Signed overflow of rd = rs + rt, judged from the three sign bits only.
  function automatic logic add_ovf(input logic rs_msb, input logic rt_msb, input logic rd_msb);
    return (rs_msb == rt_msb) && (rd_msb != rs_msb);
  endfunction

endpackage

// File: rtl/add.sv
// Shared W-bit two's-complement adder; the sum wraps modulo 2^W.
module add #(
  parameter int W = 32
) (
  output logic [W-1:0] rd,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt
);

  assign rd = rs + rt;

endmodule

// File: rtl/add_share_arbiter_rr_grant.sv
// Combinational round-robin picker: the first requester after rr_ptr
// (wrapping modulo NREQ) with req_valid set wins a one-hot grant.
module rr_grant
  import add_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  int   idx;
  logic found;

  // Scan rr_ptr+1 .. rr_ptr+NREQ and keep only the first valid requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin sharing of one signed adder among NREQ requesters. A grant
// in IDLE captures the granted operands' sum into the response registers;
// the response is held in RESP until the consumer accepts it.
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_rs,
  input  logic [NREQ*W-1:0] req_rt,
  output logic [NREQ-1:0] req_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IDW-1:0]  resp_id,
  output logic [W-1:0]    resp_rd,
  output logic            resp_ovf
);

  state_t          state;
  state_t          state_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  rr_ptr;
  logic [W-1:0]    op_rs;
  logic [W-1:0]    op_rt;
  logic [W-1:0]    sum;
  logic            take;

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr_grant (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // Route the granted requester's operands to the shared adder.
  always_comb begin
    op_rs = req_rs[int'(grant_id)*W +: W];
    op_rt = req_rt[int'(grant_id)*W +: W];
  end

  add #(.W(W)) u_add (
    .rd (sum),
    .rs (op_rs),
    .rt (op_rt)
  );

  assign take = (state == IDLE) && (|grant);

  // Grants are only visible in IDLE and are suppressed while reset is held.
  always_comb begin
    if ((state == IDLE) && rst_n) begin
      req_ready = grant;
    end else begin
      req_ready = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: grant moves to RESP, response handshake returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers and round-robin pointer; data persists after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_rd    <= '0;
      resp_ovf   <= 1'b0;
      rr_ptr     <= IDW'(NREQ - 1);
    end else if (take) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_id;
      resp_rd    <= sum;
      resp_ovf   <= add_ovf(op_rs[W-1], op_rt[W-1], sum[W-1]);
      rr_ptr     <= grant_id;
    end else if ((state == RESP) && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter: a reference model predicts each
// grant from the round-robin rule and pushes the expected response; a
// monitor compares whatever the DUT presents against the queue head.
module tb_add_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic        ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_rs;
  logic [NREQ*W-1:0] req_rt;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_rd;
  logic              resp_ovf;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_last = NREQ - 1;
  bit   m_busy = 1'b0;

  add_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_rd    (resp_rd),
    .resp_ovf   (resp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decide, from the inputs stable before the next edge,
  // who must be granted and what the resulting response must be.
  always @(negedge clk) begin : model
    int          win;
    int          c;
    longint      a;
    longint      b;
    longint      s;
    logic [3:0]  exp_rdy;
    exp_t        e;
    if (!rst_n) begin
      sb.delete();
      m_busy = 1'b0;
      m_last = NREQ - 1;
      check("rst_req_ready", {60'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    end else begin
      win = -1;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (win < 0 && req_valid[c]) win = c;
        end
      end
      exp_rdy = (win >= 0) ? (4'd1 << win) : 4'd0;
      check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
      check("resp_valid", {63'd0, resp_valid}, {63'd0, m_busy});
      if (m_busy) begin
        if (resp_ready) m_busy = 1'b0;
      end else if (win >= 0) begin
        a = longint'($signed(req_rs[win*W +: W]));
        b = longint'($signed(req_rt[win*W +: W]));
        s = a + b;
        e.id  = win;
        e.rd  = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        sb.push_back(e);
        m_last = win;
        m_busy = 1'b1;
      end
    end
  end

  // Monitor: compare the presented response with the scoreboard head,
  // popping it only when the consumer accepts.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_without_request", 64'(sb.size()), 64'd1);
      end else begin
        e = sb[0];
        check("resp_id", {62'd0, resp_id}, 64'(e.id));
        check("resp_rd", {32'd0, resp_rd}, {32'd0, e.rd});
        check("resp_ovf", {63'd0, resp_ovf}, {63'd0, e.ovf});
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one request, wait (bounded) for its grant, then check the result.
  task automatic issue(input int id, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] want_rd, input logic want_ovf);
    int t;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_rs[id*W +: W] = rs;
    req_rt[id*W +: W] = rt;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[id]) break;
    end
    if (t == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: requester %0d got no grant within 20 cycles", id);
    end else begin
      @(posedge clk); #1;
      check("dir_rd", {32'd0, resp_rd}, {32'd0, want_rd});
      check("dir_ovf", {63'd0, resp_ovf}, {63'd0, want_ovf});
      check("dir_id", {62'd0, resp_id}, 64'(id));
    end
    req_valid = '0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int order[$];
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_rs     = '0;
    req_rt     = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", {32'd0, resp_rd}, 64'd0);
    check("reset_id", {62'd0, resp_id}, 64'd0);
    check("reset_ovf", {63'd0, resp_ovf}, 64'd0);
    check("reset_ready", {60'd0, req_ready}, 64'd0);

    // All requesters busy: grants rotate 0,1,2,3,0,1, one every two cycles.
    @(posedge clk); #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_rs[i*W +: W] = $urandom;
      req_rt[i*W +: W] = $urandom;
    end
    req_valid = 4'hF;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (|req_ready) order.push_back($clog2(req_ready));
    end
    check("order_len", 64'(order.size()), 64'd6);
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      check("grant_order", 64'(order[i]), 64'(exp_order[i]));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // Directed values, including sign and wrap boundaries.
    issue(0, 32'h1C71_C71C, 32'h1C71_C71C, 32'h38E3_8E38, 1'b0);
    issue(1, 32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 1'b0);
    issue(1, 32'hFFFF_FFFB, 32'h0000_0001, 32'hFFFF_FFFC, 1'b0);
    issue(1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    issue(1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    issue(3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    repeat (2) @(posedge clk);

    // Backpressure: response held while another requester waits.
    #1;
    resp_ready = 1'b0;
    issue(2, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    req_valid[1] = 1'b1;
    req_rs[1*W +: W] = 32'h0000_0010;
    req_rt[1*W +: W] = 32'h0000_0020;
    repeat (5) @(posedge clk);
    #1;
    check("bp_hold_rd", {32'd0, resp_rd}, 64'h2345_6789);
    check("bp_hold_id", {62'd0, resp_id}, 64'd2);
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // Randomized traffic with random consumer stalls.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_rs[i*W +: W] = pick_operand();
        req_rt[i*W +: W] = pick_operand();
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Reset while a response is pending; afterwards requester 0 wins.
    #1;
    resp_ready = 1'b0;
    issue(1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    @(posedge clk); #1;
    req_valid = 4'b1001;
    req_rs[0*W +: W] = 32'h0000_0005;
    req_rt[0*W +: W] = 32'h0000_0007;
    req_rs[3*W +: W] = 32'h0000_0100;
    req_rt[3*W +: W] = 32'h0000_0200;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, resp_valid}, 64'd0);
    check("async_rst_rd", {32'd0, resp_rd}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("first_after_reset", {60'd0, req_ready}, 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
